// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared state type and default parameters for the adder sequencer
package adder_seq_pkg;

    localparam int DEF_W         = 3;
    localparam int DEF_LAT       = 1;
    localparam int DEF_DB_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SHOW   = 3'd4
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, stability window and single-cycle step pulse
module btn_debounce
    import adder_seq_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic step_pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          wait_low;
    logic          level_ok;
    logic          window_done;

    // wait_low = 0: armed, counting high cycles; wait_low = 1: counting low cycles to re-arm
    assign level_ok    = wait_low ? ~sync2 : sync2;
    assign window_done = level_ok && (cnt == CNT_LAST);

    // two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // stability counter: any break in the awaited level restarts the window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            wait_low   <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (!level_ok) begin
                cnt <= '0;
            end else if (window_done) begin
                cnt        <= '0;
                wait_low   <= ~wait_low;
                step_pulse <= ~wait_low;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - step-driven operand load / execute / show sequencer for an external adder
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int LAT       = DEF_LAT,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_step,
    input  logic [W-1:0] sw_op,
    input  logic         sw_mode,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cm1,
    input  logic [W:0]   add_data,
    input  logic         add_ov,
    output logic [W:0]   disp_data,
    output logic         ov_led,
    output logic [2:0]   state_code,
    output logic         busy,
    output logic [7:0]   op_count
);

    localparam logic [2:0] LAT_LAST = 3'(LAT);

    state_t       state_q;
    state_t       state_d;
    logic         step;
    logic         latch_a;
    logic         latch_b;
    logic         capture;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         cm1_q;
    logic [W:0]   result_q;
    logic         ov_q;
    logic [W:0]   disp_hold_q;
    logic [2:0]   lat_q;
    logic [2:0]   lat_inc;
    logic [7:0]   op_count_q;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_step),
        .step_pulse (step)
    );

    // counter value this EXEC cycle brings it to; capture happens on the LAT-th cycle
    assign lat_inc = lat_q + 3'd1;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and latch strobes; steps in EXEC are simply not looked at
    always_comb begin
        state_d = state_q;
        latch_a = 1'b0;
        latch_b = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE:   if (step) state_d = ST_LOAD_A;
            ST_LOAD_A: if (step) begin
                latch_a = 1'b1;
                state_d = ST_LOAD_B;
            end
            ST_LOAD_B: if (step) begin
                latch_b = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC:   if (lat_inc == LAT_LAST) begin
                capture = 1'b1;
                state_d = ST_SHOW;
            end
            ST_SHOW:   if (step) state_d = ST_LOAD_A;
            default:   state_d = ST_IDLE;
        endcase
    end

    // operand, latency, result and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            cm1_q      <= 1'b0;
            lat_q      <= '0;
            result_q   <= '0;
            ov_q       <= 1'b0;
            op_count_q <= '0;
        end else begin
            if (latch_a) begin
                a_q <= sw_op;
            end
            if (latch_b) begin
                b_q   <= sw_op;
                cm1_q <= sw_mode;
                lat_q <= '0;
            end else if (state_q == ST_EXEC) begin
                lat_q <= lat_inc;
            end
            if (capture) begin
                result_q   <= add_data;
                ov_q       <= add_ov;
                op_count_q <= op_count_q + 8'd1;
            end
        end
    end

    // remembers the last shown value so EXEC can keep the display frozen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_hold_q <= '0;
        end else if (state_q != ST_EXEC) begin
            disp_hold_q <= disp_data;
        end
    end

    // display mux: live switches while loading, frozen in EXEC, result in SHOW
    always_comb begin
        disp_data = '0;
        case (state_q)
            ST_LOAD_A, ST_LOAD_B: disp_data = {1'b0, sw_op};
            ST_EXEC:              disp_data = disp_hold_q;
            ST_SHOW:              disp_data = result_q;
            default:              disp_data = '0;
        endcase
    end

    assign add_a      = a_q;
    assign add_b      = b_q;
    assign add_cm1    = cm1_q;
    assign ov_led     = ov_q;
    assign state_code = state_q;
    assign busy       = (state_q == ST_EXEC);
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - scoreboard bench for adder_seq_ctrl
module tb_adder_seq_ctrl;

    typedef struct {
        logic [3:0] data;
        logic       ov;
        logic [7:0] cnt;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, rst3;
    logic       btn, btn3;
    logic [2:0] sw_op;
    logic       sw_mode;

    logic [2:0] a, b, a3, b3;
    logic       cm1, cm13, ov, ov3, ovl, ovl3, busy, busy3;
    logic [3:0] data, data3, disp, disp3;
    logic [2:0] st, st3;
    logic [7:0] cnt, cnt3;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t q3[$];
    int   busy_run = 0, busy_run3 = 0;
    logic [2:0] prev_st = 3'd0, prev_st3 = 3'd0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.W(3), .LAT(1), .DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_step(btn), .sw_op(sw_op), .sw_mode(sw_mode),
        .add_a(a), .add_b(b), .add_cm1(cm1), .add_data(data), .add_ov(ov),
        .disp_data(disp), .ov_led(ovl), .state_code(st), .busy(busy), .op_count(cnt)
    );

    adder_seq_ctrl #(.W(3), .LAT(3), .DB_CYCLES(4)) dut3 (
        .clk(clk), .rst_n(rst3), .btn_step(btn3), .sw_op(sw_op), .sw_mode(sw_mode),
        .add_a(a3), .add_b(b3), .add_cm1(cm13), .add_data(data3), .add_ov(ov3),
        .disp_data(disp3), .ov_led(ovl3), .state_code(st3), .busy(busy3), .op_count(cnt3)
    );

    // adder models: unsigned add with carry as overflow, subtract with borrow as overflow
    assign data  = cm1  ? ({1'b0, a}  - {1'b0, b})  : ({1'b0, a}  + {1'b0, b});
    assign ov    = cm1  ? (a < b)   : data[3];
    assign data3 = cm13 ? ({1'b0, a3} - {1'b0, b3}) : ({1'b0, a3} + {1'b0, b3});
    assign ov3   = cm13 ? (a3 < b3) : data3[3];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input bit which);
        if (which) btn3 = 1'b1; else btn = 1'b1;
        repeat (8) @(negedge clk);
        if (which) btn3 = 1'b0; else btn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_state(input int code, input int budget);
        int n = 0;
        while (st != 3'(code) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", int'(st), code);
    endtask

    // monitor for the LAT=1 instance: every SHOW entry pops one expected result
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_run++;
        if (st == 3'd4 && prev_st != 3'd4) begin
            if (q.size() == 0) begin
                chk("unexpected_show", 1, 0);
            end else begin
                e = q.pop_front();
                chk("show_disp", int'(disp), int'(e.data));
                chk("show_ov", int'(ovl), int'(e.ov));
                chk("show_count", int'(cnt), int'(e.cnt));
                chk("busy_cycles", busy_run, e.lat);
            end
            busy_run = 0;
        end
        if (st == 3'd0) busy_run = 0;
        prev_st = st;
    end

    // monitor for the LAT=3 instance
    always @(negedge clk) begin
        exp_t e;
        if (busy3) busy_run3++;
        if (st3 == 3'd4 && prev_st3 != 3'd4) begin
            if (q3.size() == 0) begin
                chk("unexpected_show3", 1, 0);
            end else begin
                e = q3.pop_front();
                chk("show3_disp", int'(disp3), int'(e.data));
                chk("show3_ov", int'(ovl3), int'(e.ov));
                chk("show3_count", int'(cnt3), int'(e.cnt));
                chk("busy3_cycles", busy_run3, e.lat);
            end
            busy_run3 = 0;
        end
        if (st3 == 3'd0) busy_run3 = 0;
        prev_st3 = st3;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int trans;
        int n;
        logic [2:0] pa, pb;
        logic       pm;
        logic [3:0] px;
        logic       pov;

        rst_n = 1'b0; rst3 = 1'b0; btn = 1'b0; btn3 = 1'b0; sw_op = 3'd0; sw_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(st), 0);
        chk("rst_add_a", int'(a), 0);
        chk("rst_add_b", int'(b), 0);
        chk("rst_cm1", int'(cm1), 0);
        chk("rst_disp", int'(disp), 0);
        chk("rst_ov_led", int'(ovl), 0);
        chk("rst_count", int'(cnt), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // short glitch and in-window bounce must not step
        btn = 1'b1; repeat (2) @(negedge clk);
        btn = 1'b0; repeat (10) @(negedge clk);
        chk("db_short", int'(st), 0);
        btn = 1'b1; repeat (2) @(negedge clk);
        btn = 1'b0; repeat (1) @(negedge clk);
        btn = 1'b1; repeat (2) @(negedge clk);
        btn = 1'b0; repeat (10) @(negedge clk);
        chk("db_bounce", int'(st), 0);

        // long hold gives exactly one step
        trans = 0;
        btn = 1'b1;
        for (int i = 0; i < 110; i++) begin
            logic [2:0] s0;
            if (i == 100) btn = 1'b0;
            s0 = st;
            @(negedge clk);
            if (st != s0) trans++;
        end
        chk("db_hold_trans", trans, 1);
        chk("db_hold_state", int'(st), 1);

        // add 3 + 2
        sw_op = 3'd6; @(negedge clk);
        chk("live_disp_a6", int'(disp), 6);
        sw_op = 3'd3; @(negedge clk);
        chk("live_disp_a3", int'(disp), 3);
        chk("add_a_not_latched", int'(a), 0);
        press(1'b0);
        chk("load_b_state", int'(st), 2);
        chk("add_a_latched", int'(a), 3);
        sw_op = 3'd2; sw_mode = 1'b0;
        q.push_back('{data: 4'd5, ov: 1'b0, cnt: 8'd1, lat: 1});
        press(1'b0);
        chk("show_state", int'(st), 4);
        sw_op = 3'd7; sw_mode = 1'b1; repeat (2) @(negedge clk);
        chk("hold_add_a", int'(a), 3);
        chk("hold_add_b", int'(b), 2);
        chk("hold_cm1", int'(cm1), 0);
        chk("hold_disp", int'(disp), 5);

        // subtract 2 - 5 with borrow
        press(1'b0);
        chk("ov_led_pre", int'(ovl), 0);
        sw_op = 3'd2; press(1'b0);
        sw_op = 3'd5; sw_mode = 1'b1;
        q.push_back('{data: 4'hD, ov: 1'b1, cnt: 8'd2, lat: 1});
        press(1'b0);
        press(1'b0);
        chk("sub_load_a", int'(st), 1);
        chk("ov_led_held", int'(ovl), 1);
        chk("sub_live_disp", int'(disp), 5);

        // abort on first EXEC cycle, button still held through reset release
        sw_op = 3'd4; sw_mode = 1'b0; press(1'b0);
        sw_op = 3'd1;
        btn = 1'b1;
        n = 0;
        while (!busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach_exec", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_state", int'(st), 0);
        chk("abort_add_a", int'(a), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(cnt), 0);
        chk("abort_ov_led", int'(ovl), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rel_hold_no_early", int'(st), 0);
        wait_state(1, 20);
        btn = 1'b0; repeat (8) @(negedge clk);

        // 256 operations wrap the counter
        for (int i = 0; i < 256; i++) begin
            pa = 3'(i);
            pb = 3'(i * 5 + 1);
            pm = i[0];
            px = pm ? ({1'b0, pa} - {1'b0, pb}) : ({1'b0, pa} + {1'b0, pb});
            pov = pm ? (pa < pb) : px[3];
            sw_op = pa; press(1'b0);
            sw_op = pb; sw_mode = pm;
            q.push_back('{data: px, ov: pov, cnt: 8'(i + 1), lat: 1});
            press(1'b0);
            press(1'b0);
        end
        chk("wrap_count", int'(cnt), 0);
        chk("wrap_state", int'(st), 1);

        // LAT=3 instance with a step forced into EXEC
        rst3 = 1'b1;
        press(1'b1);
        sw_op = 3'd1; press(1'b1);
        sw_op = 3'd1; sw_mode = 1'b0;
        q3.push_back('{data: 4'd2, ov: 1'b0, cnt: 8'd1, lat: 3});
        btn3 = 1'b1;
        n = 0;
        while (!busy3 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("l3_reach_exec", int'(busy3), 1);
        force dut3.step = 1'b1;
        @(negedge clk);
        release dut3.step;
        btn3 = 1'b0;
        @(negedge clk);
        chk("l3_exec_third", int'(st3), 3);
        @(negedge clk);
        chk("l3_show", int'(st3), 4);
        repeat (10) @(negedge clk);
        chk("l3_show_stays", int'(st3), 4);

        chk("sb_empty", q.size(), 0);
        chk("sb3_empty", q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
